// File: rtl/led_pwm_port.sv
// RGB LED PWM output port with double-buffered per-channel duty registers.
// Define LED_ACTIVE_LOW_EN to invert the three LED pins (reset/off drive 1).

module led_pwm_chan #(
  parameter logic INV = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [7:0] wr_data_i,
  input  logic       copy_i,
  input  logic [7:0] cnt_i,
  input  logic       en_d_i,
  output logic       led_o
);
  logic [7:0] pend_q, pend_d;
  logic [7:0] act_q, act_d;
  logic       led_q, led_d;

  // Copy reads pend_d so a write landing on the wrap bypasses straight to active.
  always_comb begin
    pend_d = wr_i ? wr_data_i : pend_q;
    act_d  = copy_i ? pend_d : act_q;
    led_d  = en_d_i && (cnt_i < act_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 8'd0;
      act_q  <= 8'd0;
      led_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      led_q  <= led_d;
    end
  end

  assign led_o = led_q ^ INV;
endmodule

module led_pwm_port #(
  parameter int PRESCALE = 47
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       led_red,
  output logic       led_green,
  output logic       led_blue,
  output logic       period_start,
  output logic       enabled
);
`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic          en_q, en_d;
  logic          ps_q, ps_d;
  logic          tick, wrap, ctrl_wr, sync;
  logic [2:0]    ch_wr, ch_led;

  assign tick    = en_q && (presc_q == PMAX);
  assign wrap    = tick && (pwm_cnt_q == 8'hFF);
  assign ctrl_wr = wr_en && (wr_addr == 2'd3);
  assign sync    = ctrl_wr && wr_data[1];

  always_comb begin
    en_d      = ctrl_wr ? wr_data[0] : en_q;
    ps_d      = wrap;
    presc_d   = presc_q;
    pwm_cnt_d = pwm_cnt_q;
    if (sync) begin
      presc_d   = '0;
      pwm_cnt_d = 8'd0;
    end else if (en_q) begin
      presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
      if (tick) pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q   <= '0;
      pwm_cnt_q <= 8'd0;
      en_q      <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      en_q      <= en_d;
      ps_q      <= ps_d;
    end
  end

  // Channel 0 = red, 1 = green, 2 = blue, matching the write address map.
  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign ch_wr[i] = wr_en && (wr_addr == 2'(i));
    led_pwm_chan #(.INV(LED_INV)) u_ch (
      .clk_i     (CLK),
      .rst_i     (RST),
      .wr_i      (ch_wr[i]),
      .wr_data_i (wr_data),
      .copy_i    (sync || wrap),
      .cnt_i     (pwm_cnt_q),
      .en_d_i    (en_d),
      .led_o     (ch_led[i])
    );
  end

  assign led_red      = ch_led[0];
  assign led_green    = ch_led[1];
  assign led_blue     = ch_led[2];
  assign period_start = ps_q;
  assign enabled      = en_q;
endmodule

// File: tb/tb_led_pwm_port.sv
// Scoreboard bench for led_pwm_port: a position-based reference model predicts
// every cycle's outputs; a monitor compares them on the falling edge.

module tb_led_pwm_port;
  localparam int P   = 2;
  localparam int PER = 256 * P;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [2:0] OFF = 3'b111;
`else
  localparam logic [2:0] OFF = 3'b000;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       led_red, led_green, led_blue, period_start, enabled;

  led_pwm_port #(.PRESCALE(P)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
    .period_start(period_start), .enabled(enabled)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] led;
    logic       ps;
    logic       en;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: m_pos counts enabled clocks within the period (0..PER-1).
  int   m_pos = 0;
  bit   m_en  = 0;
  int   m_pend[3];
  int   m_act[3];

  logic [2:0] s_led;
  logic       s_ps;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step();
    exp_t       e;
    int         cnt, ph;
    bit         wrap, ctrl, sync, en_n;
    logic [2:0] on;
    if (RST) begin
      m_en = 0; m_pos = 0;
      for (int i = 0; i < 3; i++) begin m_pend[i] = 0; m_act[i] = 0; end
      e.led = OFF; e.ps = 1'b0; e.en = 1'b0; e.cnt = 8'd0;
      q.push_back(e);
      return;
    end
    cnt  = (m_pos / P) % 256;
    ph   = m_pos % P;
    wrap = m_en && (ph == P - 1) && (cnt == 255);
    ctrl = wr_en && (wr_addr == 2'd3);
    sync = ctrl && wr_data[1];
    en_n = ctrl ? wr_data[0] : m_en;
    on   = {en_n && (cnt < m_act[0]), en_n && (cnt < m_act[1]), en_n && (cnt < m_act[2])};
    if (wr_en && wr_addr != 2'd3) m_pend[wr_addr] = int'(wr_data);
    if (sync || wrap) for (int i = 0; i < 3; i++) m_act[i] = m_pend[i];
    if (sync) m_pos = 0;
    else if (m_en) m_pos = (m_pos + 1) % PER;
    m_en  = en_n;
    e.led = on ^ OFF;
    e.ps  = wrap;
    e.en  = en_n;
    e.cnt = 8'((m_pos / P) % 256);
    q.push_back(e);
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("leds", int'({led_red, led_green, led_blue}), int'(e.led));
      chk("period_start", int'(period_start), int'(e.ps));
      chk("enabled", int'(enabled), int'(e.en));
      chk("pwm_cnt", int'(dut.pwm_cnt_q), int'(e.cnt));
    end
  end

  task automatic step(input logic we, input logic [1:0] a, input logic [7:0] d);
    @(negedge CLK); #1;
    s_led = {led_red, led_green, led_blue};
    s_ps  = period_start;
    wr_en = we; wr_addr = a; wr_data = d;
    model_step();
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK); #1;
    RST = 1'b1; wr_en = 1'b0;
    #1;
    chk("async reset leds", int'({led_red, led_green, led_blue}), int'(OFF));
    chk("async reset period_start", int'(period_start), 0);
    chk("async reset enabled", int'(enabled), 0);
    model_step();
    idle();
    idle();
    RST = 1'b0;
    idle();
  endtask

  task automatic wait_pos(input int t);
    for (int i = 0; i < 2 * PER && m_pos != t; i++) idle();
    chk("reach counter position", m_pos, t);
  endtask

  // Wait for a period_start pulse, then count on-cycles over the following full period.
  task automatic measure(input int er, input int eg, input int eb, input string tag);
    int         r = 0, g = 0, b = 0, ps = 0;
    bit         found = 0;
    logic [2:0] on;
    for (int i = 0; i < PER + 8 && !found; i++) begin
      idle();
      if (s_ps) found = 1;
    end
    chk({tag, " period_start seen"}, int'(found), 1);
    if (found) begin
      for (int i = 0; i < PER; i++) begin
        idle();
        on = s_led ^ OFF;
        r += int'(on[2]); g += int'(on[1]); b += int'(on[0]);
        ps += int'(s_ps);
      end
      chk({tag, " red on-cycles"}, r, er * P);
      chk({tag, " green on-cycles"}, g, eg * P);
      chk({tag, " blue on-cycles"}, b, eb * P);
      chk({tag, " pulses per period"}, ps, 1);
    end
  endtask

  initial begin
    int n;
    bit found;
    do_reset();

    // Basic duties, then sync-enable.
    step(1'b1, 2'd0, 8'd64);
    step(1'b1, 2'd1, 8'd0);
    step(1'b1, 2'd2, 8'd255);
    step(1'b1, 2'd3, 8'h03);
    measure(64, 0, 255, "basic");

    // Mid-period update only takes effect at the next period.
    step(1'b1, 2'd0, 8'd200);
    step(1'b1, 2'd3, 8'h03);
    wait_pos(50 * P);
    step(1'b1, 2'd0, 8'd10);
    measure(10, 0, 255, "deferred");

    // Write landing exactly on the wrap cycle bypasses to active.
    wait_pos(PER - 1);
    step(1'b1, 2'd0, 8'd77);
    measure(77, 0, 255, "bypass");

    // Disable holds the counter; re-enable resumes from there.
    wait_pos(20 * P);
    step(1'b1, 2'd3, 8'h00);
    idle();
    chk("disable leds off", int'(s_led), int'(OFF));
    repeat (5) idle();
    chk("disabled counter hold", int'(dut.pwm_cnt_q), 20);
    step(1'b1, 2'd3, 8'h01);
    n = 0; found = 0;
    for (int i = 1; i <= PER + 8 && !found; i++) begin
      idle();
      if (s_ps) begin found = 1; n = i; end
    end
    chk("resume cycles to period_start", n, (256 - 20) * P);

    // Reset while running.
    step(1'b1, 2'd0, 8'd128);
    step(1'b1, 2'd3, 8'h03);
    repeat (100) idle();
    do_reset();
    chk("post-reset pwm_cnt", int'(dut.pwm_cnt_q), 0);

    // Randomized traffic.
    step(1'b1, 2'd3, 8'h01);
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 2) do_reset();
      else if (r < 60)
        step(1'b1, 2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)));
      else if (r < 70)
        step(1'b1, 2'd3, {6'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)});
      else if (r < 80)
        step(1'b1, 2'd3, 8'h01);
      else idle();
    end

    idle();
    @(negedge CLK); #1;
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
